// File: rtl/uart_sipo_rx.sv
// rtl/uart_sipo_rx.sv - UART receive deserializer, 16x oversampled, optional parity, stop check
module uart_sipo_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 data_rx,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 active_flag,
    output logic                 done_flag
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [2:0]           state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           ptype_q, ptype_d;
    logic                 perr_pend_q, perr_pend_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_error_q, parity_error_d;
    logic                 frame_error_q, frame_error_d;
    logic                 done_q, done_d;

    logic       rx;
    logic [3:0] tick_inc;

    assign rx       = sync2_q;
    assign tick_inc = tick_q + 4'd1;

    always_comb begin
        sync1_d        = data_rx;
        sync2_d        = sync1_q;
        rx_prev_d      = sync2_q;
        state_d        = state_q;
        tick_d         = tick_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        ptype_d        = ptype_q;
        perr_pend_d    = perr_pend_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
        done_d         = done_q;

        case (state_q)
            IDLE: begin
                // Requiring a falling edge keeps a held-low break from retriggering.
                if (rx_prev_q && !rx) begin
                    state_d = START;
                    tick_d  = 4'd0;
                end
            end
            START: begin
                tick_d = tick_inc;
                if (tick_inc == TICK_MID) begin
                    if (!rx) begin
                        state_d     = DATA;
                        tick_d      = 4'd0;
                        bit_cnt_d   = 3'd0;
                        ptype_d     = parity_type;
                        perr_pend_d = 1'b0;
                        done_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                tick_d = tick_inc;
                if (tick_q == TICK_LAST) begin
                    shift_d   = {rx, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = (ptype_q == PAR_ODD || ptype_q == PAR_EVEN) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tick_d = tick_inc;
                if (tick_q == TICK_LAST) begin
                    perr_pend_d = (ptype_q == PAR_ODD) ? ~(^shift_q ^ rx) : (^shift_q ^ rx);
                    state_d     = STOP;
                end
            end
            STOP: begin
                tick_d = tick_inc;
                if (tick_q == TICK_LAST) begin
                    data_out_d     = shift_q;
                    frame_error_d  = ~rx;
                    parity_error_d = perr_pend_q;
                    data_valid_d   = 1'b1;
                    done_d         = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            state_q        <= IDLE;
            tick_q         <= 4'd0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= '0;
            ptype_q        <= 2'b00;
            perr_pend_q    <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            rx_prev_q      <= rx_prev_d;
            state_q        <= state_d;
            tick_q         <= tick_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            ptype_q        <= ptype_d;
            perr_pend_q    <= perr_pend_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            done_q         <= done_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign active_flag  = (state_q != IDLE);
    assign done_flag    = done_q;
endmodule

// File: tb/tb_uart_sipo_rx.sv
// tb/tb_uart_sipo_rx.sv - directed and randomized frames against a frame-level reference model
module tb_uart_sipo_rx;
    logic       baud_clk = 1'b0;
    logic       reset;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       active_flag;
    logic       done_flag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       done;
        logic       act;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];

    uart_sipo_rx dut (
        .baud_clk    (baud_clk),
        .reset       (reset),
        .data_rx     (data_rx),
        .parity_type (parity_type),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .active_flag (active_flag),
        .done_flag   (done_flag)
    );

    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    always @(negedge baud_clk) begin
        if (data_valid === 1'b1)
            obs_q.push_back('{cyc, data_out, parity_error, frame_error, done_flag, active_flag});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic model_perr(input logic [7:0] d, input logic [1:0] pt, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        if (pt == 2'b01) return (ones % 2) == 0;
        if (pt == 2'b10) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    // Frame drawn as 16-cycle bit slots; reset_at >= 0 aborts the frame with reset at that slot cycle.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                              input logic stopb, input int reset_at);
        logic fb[$];
        logic has_par;
        int   n;
        has_par = (pt == 2'b01) || (pt == 2'b10);
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(d[i]);
        if (has_par) fb.push_back(pbit);
        fb.push_back(stopb);
        parity_type = pt;
        n = 0;
        for (int k = 0; k < fb.size() * 16; k++) begin
            @(negedge baud_clk);
            if (k == 0) n = cyc + 1;
            data_rx = fb[k / 16];
            if (k == 40) parity_type = 2'($urandom);
            if (k == reset_at) begin
                reset   = 1'b1;
                data_rx = 1'b1;
                return;
            end
        end
        exp_q.push_back('{n + (has_par ? 169 : 153), d, model_perr(d, pt, pbit), ~stopb, 1'b1, 1'b0});
    endtask

    task automatic check_frames(input string tag);
        rec_t o, e;
        chk({tag, "/count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "/valid_cycle"}, 32'(o.at), 32'(e.at));
            chk({tag, "/data_out"}, 32'(o.data), 32'(e.data));
            chk({tag, "/parity_error"}, 32'(o.perr), 32'(e.perr));
            chk({tag, "/frame_error"}, 32'(o.ferr), 32'(e.ferr));
            chk({tag, "/done_flag"}, 32'(o.done), 32'(e.done));
            chk({tag, "/active_flag"}, 32'(o.act), 32'(e.act));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_clear(input string tag);
        chk({tag, "/data_out"}, 32'(data_out), 32'h0);
        chk({tag, "/data_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "/parity_error"}, 32'(parity_error), 32'h0);
        chk({tag, "/frame_error"}, 32'(frame_error), 32'h0);
        chk({tag, "/active_flag"}, 32'(active_flag), 32'h0);
        chk({tag, "/done_flag"}, 32'(done_flag), 32'h0);
    endtask

    initial begin
        int n;
        int act_cycles;

        reset       = 1'b1;
        data_rx     = 1'b1;
        parity_type = 2'b00;
        repeat (4) @(negedge baud_clk);
        check_outputs_clear("reset");
        reset = 1'b0;
        repeat (5) @(negedge baud_clk);

        send_frame(8'h4A, 2'b00, 1'b0, 1'b1, -1);
        repeat (3) @(negedge baud_clk);
        check_frames("no_parity_4a");

        send_frame(8'h4A, 2'b01, 1'b0, 1'b1, -1);
        send_frame(8'h4A, 2'b10, 1'b1, 1'b1, -1);
        repeat (3) @(negedge baud_clk);
        check_frames("parity_ok");

        send_frame(8'h4A, 2'b10, 1'b0, 1'b1, -1);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, -1);
        act_cycles = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge baud_clk);
            if (active_flag !== 1'b0) act_cycles++;
        end
        check_frames("parity_frame_err");
        chk("break_no_restart", 32'(act_cycles), 32'h0);
        data_rx = 1'b1;
        repeat (20) @(negedge baud_clk);

        @(negedge baud_clk);
        data_rx = 1'b0;
        n = cyc + 1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge baud_clk);
            if (j == 4) data_rx = 1'b1;
            chk("false_start/active_flag", 32'(active_flag), 32'((cyc >= n + 2) && (cyc <= n + 8)));
        end
        chk("false_start/done_flag", 32'(done_flag), 32'h1);
        check_frames("false_start");

        send_frame(8'h4A, 2'b00, 1'b0, 1'b1, 70);
        @(negedge baud_clk);
        check_outputs_clear("reset_mid_frame");
        reset = 1'b0;
        repeat (5) @(negedge baud_clk);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, -1);
        repeat (3) @(negedge baud_clk);
        check_frames("after_reset_5a");

        send_frame(8'h4A, 2'b00, 1'b0, 1'b1, -1);
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, -1);
        repeat (3) @(negedge baud_clk);
        check_frames("back_to_back");

        for (int f = 0; f < 12; f++) begin
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'b1, -1);
        end
        repeat (3) @(negedge baud_clk);
        check_frames("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
